// File: rtl/streampacker.sv
// Packs variable-size lane writes (4/8/16/64 bytes) into a 256-byte buffer, emits 128-byte chunks.
// Optional sticky multi-lane error output: define STREAMPACKER_MULTI_LANE_ERR_EN.
module streampacker #(
  parameter int unsigned BYTES_WIDTH = 8,
  parameter int unsigned OBYTES      = 128,
  parameter int unsigned IOPT_W      = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [(1<<IOPT_W)-1:0]       ivalid,
  output logic [(1<<IOPT_W)-1:0]       iready,
  input  logic [64*8-1:0]              idata,
  input  logic                         flush,
  output logic                         ovalid,
  input  logic                         oready,
  output logic [OBYTES*8-1:0]          odata,
  output logic [BYTES_WIDTH-1:0]       olen,
  output logic                         flushdone
`ifdef STREAMPACKER_MULTI_LANE_ERR_EN
  ,
  output logic                         err
`endif
);

  localparam int unsigned DEPTH = 1 << BYTES_WIDTH;
  localparam int unsigned IOPT  = 1 << IOPT_W;
  localparam logic [BYTES_WIDTH:0] DEPTH_N = (BYTES_WIDTH+1)'(DEPTH);
  localparam logic [BYTES_WIDTH:0] OB_N    = (BYTES_WIDTH+1)'(OBYTES);

  localparam logic STATE_RUN   = 1'b0;
  localparam logic STATE_FLUSH = 1'b1;

  function automatic logic [BYTES_WIDTH:0] bs_of(input int unsigned b);
    case (b)
      0:       bs_of = (BYTES_WIDTH+1)'(4);
      1:       bs_of = (BYTES_WIDTH+1)'(8);
      2:       bs_of = (BYTES_WIDTH+1)'(16);
      default: bs_of = (BYTES_WIDTH+1)'(64);
    endcase
  endfunction

  logic [7:0]             data_r [DEPTH];
  logic [7:0]             data_n [DEPTH];
  logic [BYTES_WIDTH:0]   num_r;
  logic [BYTES_WIDTH:0]   num_n;
  logic                   state_r;
  logic                   accept;
  logic [BYTES_WIDTH:0]   sel_bs;
  logic                   full_chunk;
  logic                   pop;
  logic [BYTES_WIDTH:0]   olen_x;
  logic [BYTES_WIDTH:0]   base;
  logic [BYTES_WIDTH:0]   idx;
  logic [BYTES_WIDTH:0]   src;
  logic [BYTES_WIDTH:0]   off;

  always_comb begin
    for (int unsigned b = 0; b < IOPT; b++) begin
      iready[b] = (state_r == STATE_RUN) && (num_r <= DEPTH_N - bs_of(b));
    end
  end

  // Ascending scan so the highest ready+valid lane wins.
  always_comb begin
    accept = 1'b0;
    sel_bs = '0;
    for (int unsigned b = 0; b < IOPT; b++) begin
      if (ivalid[b] && iready[b]) begin
        accept = 1'b1;
        sel_bs = bs_of(b);
      end
    end
  end

  always_comb begin
    full_chunk = (num_r >= OB_N);
    ovalid     = full_chunk || ((state_r == STATE_FLUSH) && (num_r != '0));
    olen       = full_chunk ? BYTES_WIDTH'(OBYTES) : num_r[BYTES_WIDTH-1:0];
    olen_x     = {1'b0, olen};
    pop        = ovalid && oready;
    flushdone  = (state_r == STATE_FLUSH) && (num_r == '0);
    num_n      = num_r + (accept ? sel_bs : '0) - (pop ? olen_x : '0);
    base       = pop ? (num_r - olen_x) : num_r;
  end

  always_comb begin
    for (int unsigned i = 0; i < OBYTES; i++) begin
      odata[i*8 +: 8] = (BYTES_WIDTH'(i) < olen) ? data_r[i[BYTES_WIDTH-1:0]] : '0;
    end
  end

  // Shift by olen on pop, then overlay the accepted lane at the post-shift tail.
  always_comb begin
    idx = '0;
    src = '0;
    off = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = (BYTES_WIDTH+1)'(i);
      src = idx + olen_x;
      if (pop) begin
        data_n[i[BYTES_WIDTH-1:0]] = (src >= DEPTH_N) ? '0 : data_r[src[BYTES_WIDTH-1:0]];
      end else begin
        data_n[i[BYTES_WIDTH-1:0]] = data_r[i[BYTES_WIDTH-1:0]];
      end
      off = idx - base;
      if (accept && (idx >= base) && (off < sel_bs)) begin
        data_n[i[BYTES_WIDTH-1:0]] = idata[{off[5:0], 3'b000} +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      data_r[i[BYTES_WIDTH-1:0]] <= data_n[i[BYTES_WIDTH-1:0]];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      num_r   <= '0;
      state_r <= STATE_RUN;
    end else begin
      num_r <= num_n;
      case (state_r)
        STATE_RUN:   if (flush) state_r <= STATE_FLUSH;
        STATE_FLUSH: if (num_r == '0) state_r <= STATE_RUN;
        default:     state_r <= STATE_RUN;
      endcase
    end
  end

`ifdef STREAMPACKER_MULTI_LANE_ERR_EN
  logic err_r;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_r <= 1'b0;
    end else if (|(ivalid & (ivalid - 1'b1))) begin
      err_r <= 1'b1;
    end
  end
  assign err = err_r;
`endif

endmodule

// File: tb/tb_streampacker.sv
// Bench for streampacker: byte-queue reference model checked every cycle plus directed literal checks.
module tb_streampacker;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [3:0]    ivalid = '0;
  logic [3:0]    iready;
  logic [511:0]  idata = '0;
  logic          flush = 1'b0;
  logic          ovalid;
  logic          oready = 1'b0;
  logic [1023:0] odata;
  logic [7:0]    olen;
  logic          flushdone;
`ifdef STREAMPACKER_MULTI_LANE_ERR_EN
  logic          err;
`endif

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  streampacker #(.BYTES_WIDTH(8), .OBYTES(128), .IOPT_W(2)) dut (
    .clk(clk), .rst(rst), .ivalid(ivalid), .iready(iready), .idata(idata),
    .flush(flush), .ovalid(ovalid), .oready(oready), .odata(odata),
    .olen(olen), .flushdone(flushdone)
`ifdef STREAMPACKER_MULTI_LANE_ERR_EN
    , .err(err)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: an ordered byte queue and a flushing flag.
  logic [7:0] q[$];
  logic       m_flush = 1'b0;
  logic       m_err = 1'b0;
  int         bsz [4] = '{4, 8, 16, 64};

  always @(negedge clk) begin
    int n, eolen, sel;
    logic eovalid, pop;
    logic [3:0] eready;
    logic [1023:0] eod;
    if (rst) begin
      q.delete();
      m_flush = 1'b0;
      m_err = 1'b0;
    end
    n = q.size();
    eovalid = (n >= 128) || (m_flush && n != 0);
    eolen = (n >= 128) ? 128 : n;
    for (int b = 0; b < 4; b++) eready[b] = !m_flush && (n <= 256 - bsz[b]);
    eod = '0;
    for (int i = 0; i < 128; i++) if (i < eolen) eod[i*8 +: 8] = q[i];
    chk("m_ovalid", ovalid, eovalid);
    chk("m_olen", olen, eolen);
    chk("m_iready", iready, eready);
    chk("m_flushdone", flushdone, m_flush && n == 0);
    chk("m_odata_lo", odata[511:0], eod[511:0]);
    chk("m_odata_hi", odata[1023:512], eod[1023:512]);
`ifdef STREAMPACKER_MULTI_LANE_ERR_EN
    chk("m_err", err, m_err);
`endif
    if (!rst) begin
      pop = eovalid && oready;
      sel = -1;
      for (int b = 0; b < 4; b++) if (ivalid[b] && eready[b]) sel = b;
      if (pop) repeat (eolen) void'(q.pop_front());
      if (sel >= 0) for (int k = 0; k < bsz[sel]; k++) q.push_back(idata[k*8 +: 8]);
      if (!m_flush && flush) m_flush = 1'b1;
      else if (m_flush && n == 0) m_flush = 1'b0;
      if ($countones(ivalid) > 1) m_err = 1'b1;
    end
  end

  task automatic set_data(input int start);
    for (int k = 0; k < 64; k++) idata[k*8 +: 8] = 8'(start + k);
  endtask

  task automatic cyc(input logic [3:0] v, input logic fl, input logic rdy);
    ivalid = v;
    flush  = fl;
    oready = rdy;
    @(posedge clk);
    #1;
    ivalid = '0;
    flush  = 1'b0;
    oready = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    cyc(4'b0000, 1'b1, 1'b0);
    while (!flushdone && t < 40) begin
      cyc(4'b0000, 1'b0, 1'b1);
      t++;
    end
    chk("drain_done", flushdone, 1'b1);
    cyc(4'b0000, 1'b0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1023:0] ramp;
    int fd_count;
    for (int i = 0; i < 128; i++) ramp[i*8 +: 8] = 8'(i);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_ovalid", ovalid, 1'b0);
    chk("rst_iready", iready, 4'hf);
    chk("rst_olen", olen, 8'd0);
    chk("rst_flushdone", flushdone, 1'b0);
    rst = 1'b0;

    // 32 four-byte writes complete one chunk
    for (int k = 0; k < 32; k++) begin
      set_data(4 * k);
      cyc(4'b0001, 1'b0, 1'b0);
    end
    chk("t1_ovalid", ovalid, 1'b1);
    chk("t1_olen", olen, 8'd128);
    chk("t1_odata_lo", odata[511:0], ramp[511:0]);
    chk("t1_odata_hi", odata[1023:512], ramp[1023:512]);
    cyc(4'b0000, 1'b0, 1'b1);
    chk("t1_empty", olen, 8'd0);

    // write accepted in the pop cycle lands at the head
    set_data(0);   cyc(4'b1000, 1'b0, 1'b0);
    set_data(64);  cyc(4'b1000, 1'b0, 1'b0);
    chk("t2_odata_lo", odata[511:0], ramp[511:0]);
    chk("t2_odata_hi", odata[1023:512], ramp[1023:512]);
    set_data(128); cyc(4'b1000, 1'b0, 1'b1);
    chk("t2_olen", olen, 8'd64);
    chk("t2_ovalid", ovalid, 1'b0);
    chk("t2_head", odata[7:0], 8'd128);
    drain();

    // fill to 256
    for (int k = 0; k < 4; k++) begin
      set_data(64 * k);
      cyc(4'b1000, 1'b0, 1'b0);
    end
    chk("t3_full_iready", iready, 4'h0);
    chk("t3_full_ovalid", ovalid, 1'b1);
    cyc(4'b0000, 1'b0, 1'b1);
    chk("t3_iready_after_pop", iready, 4'hf);
    chk("t3_olen_after_pop", olen, 8'd128);
    cyc(4'b0000, 1'b0, 1'b1);

    // 20-byte tail flush
    set_data(0);  cyc(4'b0100, 1'b0, 1'b0);
    set_data(16); cyc(4'b0001, 1'b0, 1'b0);
    cyc(4'b0000, 1'b1, 1'b0);
    chk("t4_iready", iready, 4'h0);
    chk("t4_ovalid", ovalid, 1'b1);
    chk("t4_olen", olen, 8'd20);
    chk("t4_pad", odata[1023:160], '0);
    chk("t4_tail", odata[159:0], ramp[159:0]);
    cyc(4'b0000, 1'b0, 1'b1);
    chk("t4_flushdone", flushdone, 1'b1);
    chk("t4_ovalid_empty", ovalid, 1'b0);
    cyc(4'b0000, 1'b0, 1'b0);
    chk("t4_flushdone_off", flushdone, 1'b0);
    chk("t4_run_iready", iready, 4'hf);

    // multi-lane priority
    set_data(200);
    cyc(4'b1011, 1'b0, 1'b0);
    chk("t5_olen", olen, 8'd64);
    chk("t5_head", odata[7:0], 8'd200);
`ifdef STREAMPACKER_MULTI_LANE_ERR_EN
    chk("t5_err_set", err, 1'b1);
`endif
    cyc(4'b0000, 1'b0, 1'b0);
    drain();
`ifdef STREAMPACKER_MULTI_LANE_ERR_EN
    chk("t5_err_sticky", err, 1'b1);
`endif

    // reset in the middle of a flush
    for (int k = 0; k < 5; k++) begin
      set_data(8 * k + 1);
      cyc(4'b0010, 1'b0, 1'b0);
    end
    cyc(4'b0000, 1'b1, 1'b0);
    chk("t6_ovalid", ovalid, 1'b1);
    chk("t6_olen", olen, 8'd40);
    rst = 1'b1;
    #2;
    chk("t6_rst_ovalid", ovalid, 1'b0);
    chk("t6_rst_iready", iready, 4'hf);
    chk("t6_rst_olen", olen, 8'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    fd_count = 0;
    repeat (5) begin
      cyc(4'b0000, 1'b0, 1'b1);
      if (flushdone) fd_count++;
    end
    chk("t6_no_flushdone", fd_count, 0);
`ifdef STREAMPACKER_MULTI_LANE_ERR_EN
    chk("t6_err_cleared", err, 1'b0);
`endif
    set_data(9);
    cyc(4'b0001, 1'b0, 1'b0);
    chk("t6_post_olen", olen, 8'd4);
    chk("t6_post_head", odata[7:0], 8'd9);
    cyc(4'b0000, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
